// File: rtl/fifo_arb_pkg.sv
// +------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and width helper for fifo_wr_arbiter |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to encode values 0..n-1; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +------------------------------------------------------------------+
// | rr_pick : combinational round-robin winner search                |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Search starts one past the last owner and wraps modulo NUM_REQ.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, i_last} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// +------------------------------------------------------------------+
// | fifo_wr_arbiter : packet-atomic round-robin FIFO write arbiter   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int GID_W     = idx_width(NUM_REQ),
  localparam int BCNT_W    = idx_width(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_w_data,
  input  logic                          i_full,
  output logic [GID_W-1:0]              o_grant_id,
  output logic                          o_busy
);

  arb_state_e        state_q, state_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;
  logic [GID_W-1:0]  last_grant_q, last_grant_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic                  pick_found;
  logic [GID_W-1:0]      pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  xfer;
  logic                  grant_done;
  logic [BCNT_W-1:0]     beat_cnt_inc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_arr[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_last  (last_grant_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    sel_valid    = i_req_valid[grant_id_q];
    sel_last     = i_req_last[grant_id_q];
    beat_cnt_inc = beat_cnt_q + BCNT_W'(1);
    o_req_ready  = '0;
    o_wr_en      = 1'b0;
    o_w_data     = req_data_arr[grant_id_q];
    xfer         = 1'b0;
    grant_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          grant_id_d = pick_idx;
        end
      end
      ST_GRANT: begin
        // Handshake is masked while rst_n is low so a reset cycle never writes.
        o_req_ready[grant_id_q] = !i_full && rst_n;
        xfer    = sel_valid && !i_full && rst_n;
        o_wr_en = xfer;
        if (xfer) begin
          beat_cnt_d = beat_cnt_inc;
          grant_done = sel_last || (beat_cnt_inc == BCNT_W'(MAX_BURST));
        end
        if (grant_done) begin
          state_d      = ST_IDLE;
          beat_cnt_d   = '0;
          last_grant_d = grant_id_q;
          grant_id_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign o_grant_id = grant_id_q;
  assign o_busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +------------------------------------------------------------------+
// | tb_fifo_wr_arbiter : directed self-checking bench                |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_last = '0;
  logic [31:0]  req_data [4];
  logic [127:0] req_data_flat;
  logic [3:0]   req_ready;
  logic         wr_en;
  logic [31:0]  w_data;
  logic         full = 1'b0;
  logic [1:0]   grant_id;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_data_flat = {req_data[3], req_data[2], req_data[1], req_data[0]};

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .MAX_BURST  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data_flat),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_wr_en     (wr_en),
    .o_w_data    (w_data),
    .i_full      (full),
    .o_grant_id  (grant_id),
    .o_busy      (busy)
  );

  function automatic logic [31:0] pat(input int r, input int b);
    return 32'hD000_0000 | (32'(r) << 16) | 32'(b);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle scoreboard on the falling edge.
  always @(negedge clk) begin : mon
    logic [3:0] acc;
    int         idx;
    if (rst_n) begin
      acc = req_valid & req_ready;
      idx = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) idx = i;
      checks++;
      if (!$onehot0(req_ready)) begin
        errors++; $display("FAIL mon_ready_onehot got=%b exp=one-hot-or-zero", req_ready);
      end
      checks++;
      if (wr_en !== (|acc)) begin
        errors++; $display("FAIL mon_wr_vs_beat got=%b exp=%b", wr_en, |acc);
      end
      checks++;
      if (wr_en && full) begin
        errors++; $display("FAIL mon_wr_while_full got=1 exp=0");
      end
      if (|acc) begin
        checks++;
        if (w_data !== req_data[idx]) begin
          errors++; $display("FAIL mon_wdata got=%h exp=%h", w_data, req_data[idx]);
        end
      end
    end
  end

  task automatic pulse_reset();
    req_valid = '0; req_last = '0; full = 1'b0;
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; full = 1'b0; req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = pat(i, 0);
    cyc(); cyc(); #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    req_valid = '0; req_last = '0; rst_n = 1'b1;
    cyc(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_packet();
    req_valid[0] = 1'b1; req_data[0] = pat(0, 0); req_last[0] = 1'b0; #1;
    checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL single_c0 busy=%b wr=%b exp=0/0", busy, wr_en); end
    cyc();
    for (int b = 0; b < 3; b++) begin
      req_data[0] = pat(0, b); req_last[0] = (b == 2); #1;
      checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_grant b=%0d busy=%b gid=%0d exp=1/0", b, busy, grant_id); end
      checks++; if (wr_en !== 1'b1 || w_data !== pat(0, b)) begin errors++; $display("FAIL single_write b=%0d wr=%b data=%h exp=1/%h", b, wr_en, w_data, pat(0, b)); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready b=%0d got=%b exp=0001", b, req_ready); end
      cyc();
    end
    req_valid = '0; req_last = '0; #1;
    checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL single_c4 busy=%b wr=%b exp=0/0", busy, wr_en); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = pat(i, 0);
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL rr_bubble n=%0d busy=%b wr=%b exp=0/0", n, busy, wr_en); end
      cyc(); #1;
      checks++; if (grant_id !== 2'(exp_order[n])) begin errors++; $display("FAIL rr_gid n=%0d got=%0d exp=%0d", n, grant_id, exp_order[n]); end
      checks++; if (wr_en !== 1'b1 || w_data !== pat(exp_order[n], 0)) begin errors++; $display("FAIL rr_write n=%0d wr=%b data=%h exp=1/%h", n, wr_en, w_data, pat(exp_order[n], 0)); end
      cyc();
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_sole_requester();
    // last owner is 0, so requester 1 alone must be re-granted after each bubble
    req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[1] = pat(1, 9);
    for (int n = 0; n < 2; n++) begin
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sole_bubble n=%0d got=%b exp=0", n, busy); end
      cyc(); #1;
      checks++; if (busy !== 1'b1 || grant_id !== 2'd1 || wr_en !== 1'b1) begin errors++; $display("FAIL sole_grant n=%0d busy=%b gid=%0d wr=%b exp=1/1/1", n, busy, grant_id, wr_en); end
      cyc();
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_burst_split();
    pulse_reset();
    req_valid = 4'b1100; req_last = 4'b1000;
    req_data[3] = pat(3, 0); req_data[2] = pat(2, 0); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle got=%b exp=0", busy); end
    cyc();
    for (int b = 0; b < 4; b++) begin
      req_data[2] = pat(2, b); #1;
      checks++; if (grant_id !== 2'd2 || wr_en !== 1'b1 || w_data !== pat(2, b)) begin errors++; $display("FAIL burst_a b=%0d gid=%0d wr=%b data=%h exp=2/1/%h", b, grant_id, wr_en, w_data, pat(2, b)); end
      cyc();
    end
    #1;
    checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL burst_cap_release busy=%b wr=%b exp=0/0", busy, wr_en); end
    cyc(); #1;
    checks++; if (grant_id !== 2'd3 || wr_en !== 1'b1 || w_data !== pat(3, 0)) begin errors++; $display("FAIL burst_other gid=%0d wr=%b data=%h exp=3/1/%h", grant_id, wr_en, w_data, pat(3, 0)); end
    cyc();
    req_valid[3] = 1'b0; req_last[3] = 1'b0; req_data[2] = pat(2, 4); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_bubble2 got=%b exp=0", busy); end
    cyc();
    for (int b = 4; b < 6; b++) begin
      req_data[2] = pat(2, b); req_last[2] = (b == 5); #1;
      checks++; if (grant_id !== 2'd2 || wr_en !== 1'b1 || w_data !== pat(2, b)) begin errors++; $display("FAIL burst_b b=%0d gid=%0d wr=%b data=%h exp=2/1/%h", b, grant_id, wr_en, w_data, pat(2, b)); end
      cyc();
    end
    req_valid = '0; req_last = '0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_end got=%b exp=0", busy); end
  endtask

  task automatic test_full_stall();
    // last owner is 2: search 3,0,1 picks requester 1
    req_valid[1] = 1'b1; req_last[1] = 1'b0; req_data[1] = pat(1, 0);
    cyc();
    for (int b = 0; b < 2; b++) begin
      req_data[1] = pat(1, b); #1;
      checks++; if (grant_id !== 2'd1 || wr_en !== 1'b1 || w_data !== pat(1, b)) begin errors++; $display("FAIL stall_pre b=%0d gid=%0d wr=%b data=%h exp=1/1/%h", b, grant_id, wr_en, w_data, pat(1, b)); end
      cyc();
    end
    req_data[1] = pat(1, 2); full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (wr_en !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL stall_out s=%0d wr=%b ready=%b exp=0/0000", s, wr_en, req_ready); end
      checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL stall_hold s=%0d busy=%b gid=%0d exp=1/1", s, busy, grant_id); end
      cyc();
    end
    full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      req_data[1] = pat(1, b); req_last[1] = (b == 3); #1;
      checks++; if (wr_en !== 1'b1 || w_data !== pat(1, b)) begin errors++; $display("FAIL stall_post b=%0d wr=%b data=%h exp=1/%h", b, wr_en, w_data, pat(1, b)); end
      cyc();
    end
    req_valid = '0; req_last = '0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    // last owner is 1: search 2,3 picks requester 3
    req_valid[3] = 1'b1; req_last[3] = 1'b0; req_data[3] = pat(3, 0);
    cyc();
    for (int b = 0; b < 2; b++) begin
      req_data[3] = pat(3, b); #1;
      checks++; if (grant_id !== 2'd3 || wr_en !== 1'b1 || w_data !== pat(3, b)) begin errors++; $display("FAIL rstmid_pre b=%0d gid=%0d wr=%b data=%h exp=3/1/%h", b, grant_id, wr_en, w_data, pat(3, b)); end
      cyc();
    end
    req_data[3] = pat(3, 2); rst_n = 1'b0; #1;
    checks++; if (wr_en !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL rstmid_during wr=%b ready=%b exp=0/0000", wr_en, req_ready); end
    cyc();
    rst_n = 1'b1; req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[1] = pat(1, 7); #1;
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_idle busy=%b gid=%0d wr=%b exp=0/0/0", busy, grant_id, wr_en); end
    cyc(); #1;
    checks++; if (grant_id !== 2'd1 || wr_en !== 1'b1 || w_data !== pat(1, 7)) begin errors++; $display("FAIL rstmid_regrant gid=%0d wr=%b data=%h exp=1/1/%h", grant_id, wr_en, w_data, pat(1, 7)); end
    cyc();
    req_valid = '0; req_last = '0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_end got=%b exp=0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i] = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_sole_requester();
    test_burst_split();
    test_full_stall();
    test_reset_mid_packet();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
